// File: rtl/bram_fifo_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bram_fifo_ctrl_if                                                 |
// | Desc   : Stream and BRAM-port bundle for bram_fifo_ctrl.                   |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
interface bram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [AW+1:0]         level;
  logic [AW-1:0]         bram_addra;
  logic [DATA_WIDTH-1:0] bram_dina;
  logic                  bram_wea;
  logic [AW-1:0]         bram_addrb;
  logic                  bram_enb;
  logic [DATA_WIDTH-1:0] bram_doutb;

  // Environment side: producer, consumer and the BRAM read port.
  modport master (
    output wr_valid, wr_data, rd_ready, bram_doutb,
    input  wr_ready, rd_valid, rd_data, level,
    input  bram_addra, bram_dina, bram_wea, bram_addrb, bram_enb
  );

  // Controller side.
  modport slave (
    input  wr_valid, wr_data, rd_ready, bram_doutb,
    output wr_ready, rd_valid, rd_data, level,
    output bram_addra, bram_dina, bram_wea, bram_addrb, bram_enb
  );
endinterface
`default_nettype wire

// File: rtl/bram_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bram_fifo_ctrl                                                    |
// | Desc   : FIFO controller around an external 1-cycle read-first SDP BRAM,   |
// |          re-timed through a 2-entry output buffer. Optional synchronous    |
// |          flush input enabled by macro BRAM_FIFO_FLUSH_EN.                  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  wire logic       clka_i,
  input  wire logic       rst_n_i,
`ifdef BRAM_FIFO_FLUSH_EN
  input  wire logic       flush_i,
`endif
  bram_fifo_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth_ptr = (AW+1)'(DEPTH);

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_d;
  logic                  obuf_head_q, obuf_head_d;
  logic [1:0]            obuf_cnt_q, obuf_cnt_d;
  logic [AW+1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] obuf_q [2];

  logic [AW:0]           w_bram_cnt;
  logic                  w_wr_ready;
  logic                  w_rd_valid;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_flush;
  logic                  w_tail;
  logic [2:0]            w_occ;

`ifdef BRAM_FIFO_FLUSH_EN
  assign w_flush = flush_i;
`else
  assign w_flush = 1'b0;
`endif

  always_comb begin
    w_bram_cnt = wr_ptr_q - rd_ptr_q;
    w_wr_ready = (w_bram_cnt != c_depth_ptr);
    w_rd_valid = (obuf_cnt_q != 2'd0);
    w_push     = bus.wr_valid & w_wr_ready & ~w_flush;
    w_pop      = w_rd_valid & bus.rd_ready & ~w_flush;
    // A word already in flight reserves its output-buffer slot.
    w_occ      = {1'b0, obuf_cnt_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    w_issue    = (w_bram_cnt != '0) & (w_occ < 3'd2) & ~w_flush;
    w_tail     = obuf_head_q ^ obuf_cnt_q[0];
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q + (AW+1)'(w_push);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(w_issue);
    inflight_d  = w_issue;
    obuf_head_d = obuf_head_q ^ w_pop;
    obuf_cnt_d  = obuf_cnt_q + {1'b0, inflight_q} - {1'b0, w_pop};
    level_d     = level_q + (AW+2)'(w_push) - (AW+2)'(w_pop);
  end

  always_ff @(posedge clka_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
      obuf_head_q <= 1'b0;
      obuf_cnt_q  <= 2'd0;
      level_q     <= '0;
    end else if (w_flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
      obuf_head_q <= 1'b0;
      obuf_cnt_q  <= 2'd0;
      level_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      obuf_head_q <= obuf_head_d;
      obuf_cnt_q  <= obuf_cnt_d;
      level_q     <= level_d;
    end
  end

  // The tail slot is never the head while a word is still being presented.
  for (genvar gi = 0; gi < 2; gi++) begin : g_obuf
    always_ff @(posedge clka_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        obuf_q[gi] <= '0;
      end else if (inflight_q && !w_flush && (w_tail == 1'(gi))) begin
        obuf_q[gi] <= bus.bram_doutb;
      end
    end
  end

  assign bus.wr_ready   = w_wr_ready;
  assign bus.rd_valid   = w_rd_valid;
  assign bus.rd_data    = obuf_q[obuf_head_q];
  assign bus.level      = level_q;
  assign bus.bram_addra = wr_ptr_q[AW-1:0];
  assign bus.bram_dina  = bus.wr_data;
  assign bus.bram_wea   = w_push;
  assign bus.bram_addrb = rd_ptr_q[AW-1:0];
  assign bus.bram_enb   = w_issue;

endmodule
`default_nettype wire

// File: tb/tb_bram_fifo_ctrl.sv
`default_nettype none
// Testbench for bram_fifo_ctrl: BRAM model, scoreboard monitor, vector table and
// multi-cycle sequences (fill/drain, streaming, random, reset, optional flush).
module tb_bram_fifo_ctrl;
  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;
`ifdef BRAM_FIFO_FLUSH_EN
  logic flush;
`endif

  int errors = 0;
  int checks = 0;
  int m_lvl  = 0;
  logic [DW-1:0] sb [$];

  bram_fifo_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bif ();

  bram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clka_i  (clk),
    .rst_n_i (rst_n),
`ifdef BRAM_FIFO_FLUSH_EN
    .flush_i (flush),
`endif
    .bus     (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first simple-dual-port BRAM, 1-cycle read latency.
  logic [DW-1:0] bram_mem [DEPTH];
  always @(posedge clk) begin
    if (bif.bram_enb) bif.bram_doutb <= bram_mem[bif.bram_addrb];
    if (bif.bram_wea) bram_mem[bif.bram_addra] <= bif.bram_dina;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: samples handshakes at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_lvl = 0;
    end
`ifdef BRAM_FIFO_FLUSH_EN
    else if (flush) begin
      chk("level_at_flush", 32'(bif.level), m_lvl);
      sb.delete();
      m_lvl = 0;
    end
`endif
    else begin
      chk("level_model", 32'(bif.level), m_lvl);
      if (bif.rd_valid && bif.rd_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_empty: got pop 0x%0h expected no data", bif.rd_data);
        end else begin
          chk("sb_rd_data", bif.rd_data, sb.pop_front());
        end
        m_lvl--;
      end
      if (bif.wr_valid && bif.wr_ready) begin
        sb.push_back(bif.wr_data);
        m_lvl++;
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          wv;
    logic [31:0] wd;
    bit          rr;
    bit          e_rv;
    logic [31:0] e_rd;
    int          e_lvl;
    bit          e_wrdy;
    bit          e_wea;
    bit          e_enb;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int acc, sent, got, bubbles, first_pop, cyc, over, seen;
    bit started;

    //             wv  wd      rr   rv  rd      lvl wrdy wea enb
    vecs[0]  = '{1'b1, 32'hA5, 1'b1, 1'b0, 32'h0,  0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA5, 1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h11, 1'b1, 1'b0, 32'h0,  0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 32'h22, 1'b1, 1'b0, 32'h0,  1, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  2, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h11, 2, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h11, 2, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h22, 1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    bif.wr_valid = 1'b0;
    bif.wr_data  = '0;
    bif.rd_ready = 1'b0;
`ifdef BRAM_FIFO_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_rd_valid", 32'(bif.rd_valid), 0);
    chk("rst_level",    32'(bif.level), 0);
    chk("rst_wr_ready", 32'(bif.wr_ready), 1);
    chk("rst_wea",      32'(bif.bram_wea), 0);
    chk("rst_enb",      32'(bif.bram_enb), 0);

    // Vector table: single-word latency and a two-word burst with back-pressure.
    for (int i = 0; i < 11; i++) begin
      bif.wr_valid = vecs[i].wv;
      bif.wr_data  = vecs[i].wd;
      bif.rd_ready = vecs[i].rr;
      @(negedge clk);
      chk($sformatf("vec%0d_rd_valid", i), 32'(bif.rd_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk($sformatf("vec%0d_rd_data", i), bif.rd_data, vecs[i].e_rd);
      chk($sformatf("vec%0d_level", i),    32'(bif.level), vecs[i].e_lvl);
      chk($sformatf("vec%0d_wr_ready", i), 32'(bif.wr_ready), 32'(vecs[i].e_wrdy));
      chk($sformatf("vec%0d_wea", i),      32'(bif.bram_wea), 32'(vecs[i].e_wea));
      chk($sformatf("vec%0d_enb", i),      32'(bif.bram_enb), 32'(vecs[i].e_enb));
      @(posedge clk); #1;
    end
    bif.wr_valid = 1'b0;

    // Fill to capacity with no consumer, then drain.
    bif.rd_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      bif.wr_valid = 1'b1;
      bif.wr_data  = 32'(i);
      @(negedge clk);
      if (bif.wr_ready) acc++;
      @(posedge clk); #1;
    end
    bif.wr_valid = 1'b0;
    chk("fill_accepted", acc, 18);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("full_level",    32'(bif.level), 18);
    chk("full_wr_ready", 32'(bif.wr_ready), 0);
    @(posedge clk); #1;
    bif.rd_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_ready_after_pop", 32'(bif.wr_ready), 1);
    cyc = 0;
    while ((sb.size() != 0) && (cyc < 100)) begin @(posedge clk); #1; cyc++; end
    chk("drain_empty", sb.size(), 0);
    @(negedge clk);
    chk("drain_level", 32'(bif.level), 0);
    @(posedge clk); #1;

    // Continuous streaming: 100 words, no bubbles after initial fill.
    sent = 0; got = 0; bubbles = 0; first_pop = -1; started = 1'b0;
    bif.rd_ready = 1'b1;
    for (int c = 0; c < 400 && got < 100; c++) begin
      bif.wr_valid = (sent < 100);
      bif.wr_data  = 32'(sent * 3);
      @(negedge clk);
      if (bif.wr_valid && bif.wr_ready) sent++;
      if (bif.rd_valid) begin
        if (!started) first_pop = c;
        started = 1'b1;
        got++;
      end else if (started) begin
        bubbles++;
      end
      @(posedge clk); #1;
    end
    bif.wr_valid = 1'b0;
    chk("stream_got", got, 100);
    chk("stream_first_pop", first_pop, 3);
    chk("stream_bubbles", bubbles, 0);

    // Random traffic with level bound tracking.
    sent = 0; over = 0; cyc = 0;
    while (((sent < 2000) || (sb.size() != 0)) && (cyc < 30000)) begin
      bif.wr_valid = (sent < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
      bif.wr_data  = $urandom;
      bif.rd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bif.wr_valid && bif.wr_ready) sent++;
      if (32'(bif.level) > 18) over++;
      @(posedge clk); #1;
      cyc++;
    end
    bif.wr_valid = 1'b0;
    bif.rd_ready = 1'b0;
    chk("rand_sent", sent, 2000);
    chk("rand_level_over", over, 0);
    chk("rand_sb_empty", sb.size(), 0);

    // Reset mid-operation discards contents.
    for (int i = 0; i < 10; i++) begin
      bif.wr_valid = 1'b1;
      bif.wr_data  = 32'h100 + 32'(i);
      @(posedge clk); #1;
    end
    bif.wr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_level", 32'(bif.level), 10);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_valid", 32'(bif.rd_valid), 0);
    chk("midrst_level",    32'(bif.level), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bif.wr_valid = 1'b1;
    bif.wr_data  = 32'h77;
    bif.rd_ready = 1'b1;
    @(posedge clk); #1;
    bif.wr_data  = 32'h78;
    @(posedge clk); #1;
    bif.wr_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (bif.rd_valid) begin
        seen = 1;
        chk("post_rst_first", bif.rd_data, 32'h77);
      end
      @(posedge clk); #1;
    end
    chk("post_rst_seen", seen, 1);
    repeat (6) begin @(posedge clk); #1; end

`ifdef BRAM_FIFO_FLUSH_EN
    // Flush with a word in flight and a concurrent push.
    bif.rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bif.wr_valid = 1'b1;
      bif.wr_data  = 32'h200 + 32'(i);
      @(posedge clk); #1;
    end
    bif.wr_data  = 32'h205;
    bif.rd_ready = 1'b1;
    @(posedge clk); #1;
    bif.wr_data  = 32'h99;
    bif.rd_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_pre_level", 32'(bif.level), 5);
    chk("flush_wea", 32'(bif.bram_wea), 0);
    chk("flush_enb", 32'(bif.bram_enb), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    bif.wr_valid = 1'b0;
    bif.rd_ready = 1'b1;
    @(negedge clk);
    chk("flush_level", 32'(bif.level), 0);
    chk("flush_rd_valid", 32'(bif.rd_valid), 0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bif.rd_valid) seen++;
    end
    chk("flush_no_output", seen, 0);
    @(posedge clk); #1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
